// File: rtl/i2c_target.sv
// I2C target: oversamples scl/sda on core_clk, matches a 7-bit address, ACKs writes
// into rx_data and serves read bytes from tx_data. Never stretches scl.
module i2c_target #(
    parameter logic [6:0] SLAVE_ADDR = 7'h42
) (
    input  logic       core_clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       scl,
    inout  wire        sda,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_ADDR_ACK  = 3'd2,
        ST_WRITE     = 3'd3,
        ST_WRITE_ACK = 3'd4,
        ST_READ      = 3'd5,
        ST_READ_ACK  = 3'd6,
        ST_IGNORE    = 3'd7
    } state_t;

    logic       scl_meta_r, scl_sync_r, scl_prev_r;
    logic       sda_meta_r, sda_sync_r, sda_prev_r;
    logic       scl_rise_s, scl_fall_s, start_s, stop_s;
    logic [7:0] shift_in_s;

    state_t     state_r;
    logic [2:0] bit_cnt_r;
    logic [7:0] shift_r;
    logic       rw_r;
    logic       ack_phase_r;
    logic       sda_low_r;
    logic [7:0] rx_data_r;
    logic       rx_valid_r;
    logic       tx_ready_r;
    logic       busy_r;

    // Two-flop synchronizers plus one history stage for edge detection.
    always_ff @(posedge core_clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_meta_r <= 1'b1;
            scl_sync_r <= 1'b1;
            scl_prev_r <= 1'b1;
            sda_meta_r <= 1'b1;
            sda_sync_r <= 1'b1;
            sda_prev_r <= 1'b1;
        end else begin
            scl_meta_r <= scl;
            scl_sync_r <= scl_meta_r;
            scl_prev_r <= scl_sync_r;
            sda_meta_r <= sda;
            sda_sync_r <= sda_meta_r;
            sda_prev_r <= sda_sync_r;
        end
    end

    assign scl_rise_s = scl_sync_r & ~scl_prev_r;
    assign scl_fall_s = ~scl_sync_r & scl_prev_r;
    // Requiring scl high in both samples means a simultaneous scl edge counts as data.
    assign start_s    = scl_sync_r & scl_prev_r & sda_prev_r & ~sda_sync_r;
    assign stop_s     = scl_sync_r & scl_prev_r & ~sda_prev_r & sda_sync_r;
    assign shift_in_s = {shift_r[6:0], sda_sync_r};

    // Protocol FSM with registered bus drive and handshake outputs.
    always_ff @(posedge core_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            bit_cnt_r   <= 3'd0;
            shift_r     <= 8'hFF;
            rw_r        <= 1'b0;
            ack_phase_r <= 1'b0;
            sda_low_r   <= 1'b0;
            rx_data_r   <= 8'h00;
            rx_valid_r  <= 1'b0;
            tx_ready_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            rx_valid_r <= 1'b0;
            tx_ready_r <= 1'b0;
            if (!enable) begin
                state_r   <= ST_IDLE;
                sda_low_r <= 1'b0;
                busy_r    <= 1'b0;
            end else if (start_s) begin
                state_r   <= ST_ADDR;
                bit_cnt_r <= 3'd0;
                sda_low_r <= 1'b0;
                busy_r    <= 1'b0;
            end else if (stop_s) begin
                state_r   <= ST_IDLE;
                sda_low_r <= 1'b0;
                busy_r    <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        sda_low_r <= 1'b0;
                    end
                    ST_ADDR: begin
                        if (scl_rise_s) begin
                            shift_r   <= shift_in_s;
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                            if (bit_cnt_r == 3'd7) begin
                                rw_r        <= sda_sync_r;
                                ack_phase_r <= 1'b0;
                                if ((shift_r[6:0] == SLAVE_ADDR) && (SLAVE_ADDR != 7'h00)) begin
                                    state_r <= ST_ADDR_ACK;
                                    busy_r  <= 1'b1;
                                end else begin
                                    state_r <= ST_IGNORE;
                                end
                            end
                        end
                    end
                    ST_ADDR_ACK: begin
                        if (scl_fall_s) begin
                            if (!ack_phase_r) begin
                                sda_low_r   <= 1'b1;
                                ack_phase_r <= 1'b1;
                            end else begin
                                bit_cnt_r <= 3'd0;
                                if (rw_r) begin
                                    // Load cycle: bit 7 goes onto the bus immediately.
                                    shift_r    <= tx_valid ? tx_data : 8'hFF;
                                    sda_low_r  <= tx_valid ? ~tx_data[7] : 1'b0;
                                    tx_ready_r <= tx_valid;
                                    state_r    <= ST_READ;
                                end else begin
                                    sda_low_r <= 1'b0;
                                    state_r   <= ST_WRITE;
                                end
                            end
                        end
                    end
                    ST_WRITE: begin
                        if (scl_rise_s) begin
                            shift_r   <= shift_in_s;
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                            if (bit_cnt_r == 3'd7) begin
                                rx_data_r   <= shift_in_s;
                                rx_valid_r  <= 1'b1;
                                ack_phase_r <= 1'b0;
                                state_r     <= ST_WRITE_ACK;
                            end
                        end
                    end
                    ST_WRITE_ACK: begin
                        if (scl_fall_s) begin
                            if (!ack_phase_r) begin
                                sda_low_r   <= 1'b1;
                                ack_phase_r <= 1'b1;
                            end else begin
                                sda_low_r <= 1'b0;
                                bit_cnt_r <= 3'd0;
                                state_r   <= ST_WRITE;
                            end
                        end
                    end
                    ST_READ: begin
                        if (scl_fall_s) begin
                            if (bit_cnt_r == 3'd7) begin
                                sda_low_r   <= 1'b0;
                                ack_phase_r <= 1'b0;
                                state_r     <= ST_READ_ACK;
                            end else begin
                                sda_low_r <= ~shift_r[6];
                                shift_r   <= {shift_r[6:0], 1'b1};
                                bit_cnt_r <= bit_cnt_r + 3'd1;
                            end
                        end
                    end
                    ST_READ_ACK: begin
                        if (scl_rise_s && !ack_phase_r) begin
                            if (sda_sync_r) begin
                                state_r <= ST_IGNORE;
                                busy_r  <= 1'b0;
                            end else begin
                                ack_phase_r <= 1'b1;
                            end
                        end else if (scl_fall_s && ack_phase_r) begin
                            shift_r    <= tx_valid ? tx_data : 8'hFF;
                            sda_low_r  <= tx_valid ? ~tx_data[7] : 1'b0;
                            tx_ready_r <= tx_valid;
                            bit_cnt_r  <= 3'd0;
                            state_r    <= ST_READ;
                        end else begin
                            sda_low_r <= 1'b0;
                        end
                    end
                    ST_IGNORE: begin
                        sda_low_r <= 1'b0;
                    end
                    default: begin
                        state_r   <= ST_IDLE;
                        sda_low_r <= 1'b0;
                        busy_r    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sda      = sda_low_r ? 1'b0 : 1'bz;
    assign rx_data  = rx_data_r;
    assign rx_valid = rx_valid_r;
    assign tx_ready = tx_ready_r;
    assign busy     = busy_r;

endmodule

// File: tb/tb_i2c_target.sv
// Randomized bench for i2c_target: a bit-level I2C controller model drives the bus and
// a transaction-level model predicts ACKs, written bytes, read bytes and handshakes.
module tb_i2c_target;

    logic       core_clk = 1'b0;
    logic       rst_n    = 1'b0;
    logic       enable   = 1'b1;
    logic       scl      = 1'b1;
    logic       ctl_low  = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    wire        sda;
    wire        tx_ready;
    wire  [7:0] rx_data;
    wire        rx_valid;
    wire        busy;

    assign sda = ctl_low ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_target #(.SLAVE_ADDR(7'h42)) dut (
        .core_clk (core_clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .scl      (scl),
        .sda      (sda),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .busy     (busy)
    );

    always #5 core_clk = ~core_clk;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] rx_log [0:1023];
    int         rx_cnt = 0;
    int         tx_ready_cnt = 0;
    logic [7:0] exp_rx [0:1023];
    int         exp_rx_cnt = 0;
    int         rx_checked = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Log every rx_valid pulse and count tx_ready pulses, sampled away from posedge.
    always @(negedge core_clk) begin
        if (rx_valid) begin
            rx_log[rx_cnt[9:0]] <= rx_data;
            rx_cnt <= rx_cnt + 1;
        end
        if (tx_ready) tx_ready_cnt <= tx_ready_cnt + 1;
    end

    // One scl period of 200 ns (20 core_clk); data changes mid-low, sampled mid-high.
    task automatic clock_bit(input logic drive, output logic sampled);
        #50 ctl_low = !drive;
        #50 scl = 1'b1;
        #50 sampled = sda;
        #50 scl = 1'b0;
    endtask

    task automatic i2c_start();
        if (!scl) begin
            #50 ctl_low = 1'b0;
            #50 scl = 1'b1;
            #50;
        end
        ctl_low = 1'b1;
        #100 scl = 1'b0;
    endtask

    task automatic i2c_stop();
        #50 ctl_low = 1'b1;
        #50 scl = 1'b1;
        #100 ctl_low = 1'b0;
        #100;
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
        clock_bit(1'b1, s);
        ack = !s;
    endtask

    task automatic read_bits(output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, s);
            b[i] = s;
        end
    endtask

    task automatic check_rx_log();
        #30;
        check_eq("rx_count", rx_cnt, exp_rx_cnt);
        while (rx_checked < exp_rx_cnt && rx_checked < rx_cnt) begin
            check_eq("rx_data", rx_log[rx_checked], exp_rx[rx_checked]);
            rx_checked++;
        end
    endtask

    task automatic xact_write(input logic [7:0] addr, input logic [2:0][7:0] d,
                              input int nb, input logic do_stop);
        logic ack;
        logic match;
        match = (addr[7:1] == 7'h42);
        i2c_start();
        write_byte(addr, ack);
        check_eq("w_addr_ack", ack, match);
        #20 check_eq("w_busy", busy, match);
        for (int k = 0; k < nb; k++) begin
            write_byte(d[k], ack);
            check_eq("w_data_ack", ack, match);
            if (match) begin
                exp_rx[exp_rx_cnt] = d[k];
                exp_rx_cnt++;
            end
        end
        check_rx_log();
        if (do_stop) begin
            i2c_stop();
            #20 check_eq("w_busy_stop", busy, 1'b0);
        end
    endtask

    task automatic xact_read(input logic [7:0] addr, input logic [2:0][7:0] txd,
                             input logic [2:0] txv, input int nb);
        logic       ack;
        logic       s;
        logic       match;
        logic [7:0] got;
        int         ready0;
        int         exp_ready;
        match     = (addr[7:1] == 7'h42);
        ready0    = tx_ready_cnt;
        exp_ready = 0;
        tx_data   = txd[0];
        tx_valid  = txv[0];
        i2c_start();
        write_byte(addr, ack);
        check_eq("r_addr_ack", ack, match);
        if (match) begin
            for (int k = 0; k < nb; k++) begin
                read_bits(got);
                check_eq("r_data", got, txv[k] ? txd[k] : 8'hFF);
                if (txv[k]) exp_ready++;
                if (k < nb - 1) begin
                    tx_data  = txd[k+1];
                    tx_valid = txv[k+1];
                    clock_bit(1'b0, s);
                end else begin
                    clock_bit(1'b1, s);
                    #20 check_eq("r_busy_nack", busy, 1'b0);
                end
            end
        end
        #20 check_eq("tx_ready_count", tx_ready_cnt - ready0, exp_ready);
        i2c_stop();
        #20 check_eq("r_busy_stop", busy, 1'b0);
    endtask

    initial begin
        logic [2:0][7:0] d;
        logic [2:0]      v;
        logic [7:0]      addr;
        logic            s;
        logic            ack;

        #23;
        check_eq("rst_sda", sda, 1'b1);
        #80 rst_n = 1'b1;
        #20;
        check_eq("rst_rx_data", rx_data, 8'h00);
        check_eq("rst_rx_valid", rx_valid, 1'b0);
        check_eq("rst_tx_ready", tx_ready, 1'b0);
        check_eq("rst_busy", busy, 1'b0);

        xact_write(8'h84, {8'h00, 8'h3C, 8'hA5}, 2, 1'b1);
        xact_read(8'h85, {8'h00, 8'hC3, 8'h5A}, 3'b011, 2);
        xact_write(8'h90, {8'h00, 8'h00, 8'h11}, 1, 1'b1);
        xact_write(8'h84, {8'h00, 8'h00, 8'h77}, 1, 1'b0);
        xact_read(8'h85, {8'h00, 8'h00, 8'hE1}, 3'b001, 1);
        check_eq("rs_rx_data", rx_data, 8'h77);
        xact_read(8'h85, {8'h00, 8'h00, 8'h12}, 3'b000, 1);

        // Reset pulsed while the target holds the address ACK low.
        i2c_start();
        for (int i = 7; i >= 0; i--) clock_bit(addr_bit(8'h84, i), s);
        #50 ctl_low = 1'b0;
        #50 scl = 1'b1;
        #50 check_eq("ack_before_rst", sda, 1'b0);
        rst_n = 1'b0;
        #1 check_eq("rst_release_sda", sda, 1'b1);
        check_eq("rst_busy_mid", busy, 1'b0);
        #20 rst_n = 1'b1;
        #29 scl = 1'b0;
        i2c_stop();
        xact_write(8'h84, {8'h00, 8'h00, 8'h6B}, 1, 1'b1);

        // STOP after four data bits discards the partial byte.
        i2c_start();
        write_byte(8'h84, ack);
        check_eq("abort_addr_ack", ack, 1'b1);
        for (int i = 0; i < 4; i++) clock_bit(i[0], s);
        i2c_stop();
        #20 check_eq("abort_busy", busy, 1'b0);
        check_eq("abort_sda", sda, 1'b1);
        check_rx_log();

        // Dropping enable during the ACK releases sda within a cycle.
        i2c_start();
        for (int i = 7; i >= 0; i--) clock_bit(addr_bit(8'h84, i), s);
        #50 ctl_low = 1'b0;
        #50 scl = 1'b1;
        #20 check_eq("en_ack_low", sda, 1'b0);
        enable = 1'b0;
        #12 check_eq("en_release_sda", sda, 1'b1);
        check_eq("en_busy", busy, 1'b0);
        #18 scl = 1'b0;
        enable = 1'b1;
        i2c_stop();

        for (int t = 0; t < 30; t++) begin
            case ($urandom_range(0, 3))
                0, 1:    addr = {7'h42, 1'b0};
                2:       addr = 8'($urandom_range(0, 255));
                default: addr = 8'h00;
            endcase
            addr[0] = 1'($urandom_range(0, 1));
            for (int k = 0; k < 3; k++) begin
                d[k] = 8'($urandom_range(0, 255));
                v[k] = 1'($urandom_range(0, 1));
            end
            if (addr[0]) xact_read(addr, d, v, $urandom_range(1, 3));
            else xact_write(addr, d, $urandom_range(1, 3), 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    function automatic logic addr_bit(input logic [7:0] a, input int i);
        return a[i];
    endfunction

endmodule

// File: doc/i2c_target.md
# i2c_target

I2C target (slave) that responds to the bus traffic generated by `i2c_controller`. It oversamples `scl`/`sda` on `core_clk` and detects START, repeated START and STOP. It matches a 7-bit address, accepts written bytes into a receive port, and serves read bytes from a transmit port. It ACKs every matched address and written byte and never stretches `scl`.

## Interface
- `SLAVE_ADDR`, 7'h42, 7-bit bus address this target answers to
- `core_clk`  in  1  sole clock; must be at least 16x the `scl` frequency
- `rst_n`  in  1  reset, asynchronous, active-low
- `enable`  in  1  level; while 0 the target ignores the bus and releases `sda`
- `scl`  in  1  bus clock, input only
- `sda`  inout  1  open-drain; target drives only 0 or `'bz`
- `tx_data`  in  8  byte to return on a read
- `tx_valid`  in  1  `tx_data` is valid
- `tx_ready`  out  1  1-cycle pulse: `tx_data` consumed into the shift register
- `rx_data`  out  8  last byte written by the controller
- `rx_valid`  out  1  1-cycle pulse: `rx_data` updated
- `busy`  out  1  high from address match until STOP, START or NACK

## Operation
- **Input sampling:** `scl` and `sda` pass through 2-flop synchronizers plus one history register.
  - `scl_rise` / `scl_fall` are derived from the synchronized `scl`.
- **Bus conditions** are only recognised when the synchronized `scl` is 1 in both the current and previous sample:
  - START: synchronized `sda` 1 -> 0.
  - STOP: synchronized `sda` 0 -> 1.
  - If an `scl` edge and an `sda` edge are seen in the same cycle, treat it as data, not START/STOP.
- **States:** IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, IGNORE.
- **Global transitions:**
  - START in any state -> ADDR; bit counter cleared, `sda` released.
  - STOP in any state -> IDLE; `sda` released, `busy` = 0.
  - `enable` = 0 -> IDLE on the next cycle, regardless of state.
- **ADDR:**
  - Shift `sda` in MSB first on each `scl_rise`; the 3-bit counter counts 8 bits.
  - After the 8th rise, compare bits [7:1] against `SLAVE_ADDR`; bit 0 is `rw`.
  - Match -> ADDR_ACK and `busy` = 1. Mismatch -> IGNORE.
  - General call (0x00) is not matched.
- **ADDR_ACK:**
  - Next `scl_fall`: drive `sda` low.
  - Following `scl_fall`: release `sda`, then:
    - `rw` = 0 -> WRITE.
    - `rw` = 1 -> load the shift register and go to READ.
- **WRITE:**
  - Shift 8 bits on `scl_rise`.
  - After the 8th rise, update `rx_data` and pulse `rx_valid` -> WRITE_ACK.
- **WRITE_ACK:** drive low on the next `scl_fall`, release on the following `scl_fall`, -> WRITE.
- **Shift-register load** (on entry to READ, and on every following byte):
  - `tx_valid` = 1: load `tx_data` and pulse `tx_ready`.
  - `tx_valid` = 0 (underrun): load 8'hFF, no `tx_ready` pulse.
- **READ:**
  - Drive bit 7 on the load cycle.
  - Present the next bit on each `scl_fall`: bit value 0 -> drive low, 1 -> release.
  - On the 8th `scl_fall` after load, release `sda` -> READ_ACK.
- **READ_ACK:**
  - Sample `sda` on `scl_rise`.
  - 0 (ACK): on the next `scl_fall`, load the next byte -> READ.
  - 1 (NACK): -> IGNORE, `busy` = 0.
- **IGNORE:** `sda` released; wait for START or STOP.

## Timing
- **Reset values:** `sda` = `'bz`, `rx_data` = 8'h00, `rx_valid` = 0, `tx_ready` = 0, `busy` = 0, state IDLE, shift register 8'hFF.
- **Pin-to-event latency:** 3 `core_clk` (2 sync + 1 edge detect).
- **`sda` response:** driven/released on the cycle after the detected event, i.e. ≤ 4 `core_clk` after the `scl` pin falls.
- **`rx_valid`:** pulses exactly 1 cycle, on the cycle after the 8th `scl_rise` of the data byte is detected.
- **`tx_ready`:** pulses exactly 1 cycle, on the load cycle. `tx_data` must be stable in that cycle.
- **Repeated START mid-byte:** discards the partial byte; no `rx_valid` pulse.
- **Async reset mid-transfer:** releases `sda` immediately, without waiting for a clock.
- **Deasserting `enable` mid-ACK:** releases `sda` within 1 cycle.

## Test plan
- **Write, 2 bytes:** START, 0x84, 0xA5, 0x3C, STOP -> three ACKs on `sda`; `rx_valid` pulses twice with `rx_data` 0xA5 then 0x3C; `busy` 1 -> 0 at STOP.
- **Read, 2 bytes:** `tx_data` 0x5A then 0xC3 with `tx_valid` = 1; START, 0x85, controller ACK, then NACK -> bus carries 0x5A, 0xC3; `tx_ready` pulses twice; state IGNORE after the NACK.
- **Address mismatch:** START, 0x90, 0x11, STOP -> no ACK (`sda` stays high on the 9th clock); no `rx_valid`; `busy` stays 0.
- **Repeated START:** START, 0x84, 0x77, START, 0x85, read 1 byte with NACK, STOP -> `rx_data` = 0x77; the read returns `tx_data`; second address ACKed.
- **Read underrun:** `tx_valid` = 0, START, 0x85 -> byte 0xFF on the bus; no `tx_ready` pulse.
- **Abort mid-byte:** `rst_n` pulsed low mid-byte, or STOP after 4 data bits -> `sda` released immediately (reset) or at STOP; state IDLE; no `rx_valid`; the next full transaction completes correctly.
